// File: rtl/lbus_rx_to_mfb.sv
// rtl/lbus_rx_to_mfb.sv - CMAC 100G RX LBUS to single-region 512-bit MFB adapter with overflow truncation
//
// Purpose: registers each 4x128b LBUS word and remaps its bytes into one MFB word.
// A first-word-fall-through FIFO absorbs consumer stalls.
// On FIFO exhaustion, frames are truncated or dropped cleanly and counted in DROP_CNT.
// Ports:
//   CLK, RESET          sole clock; asynchronous active-high reset
//   LBUS_*              CMAC RX LBUS word: segment s = bits [128*s+127:128*s], byte 0 in the top byte;
//                       LBUS_MTY segment s = bits [4*s+3:4*s]
//   TX_MFB_*            MFB user side, item i = bits [8*i+7:8*i]; SRC_RDY/DST_RDY handshake
//   DROP_CNT            wrapping count of truncated or dropped frames
module lbus_rx_to_mfb #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32,
  parameter     DEVICE     = "ULTRASCALE"
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [511:0]         LBUS_DATA,
  input  logic [3:0]           LBUS_ENA,
  input  logic [3:0]           LBUS_SOP,
  input  logic [3:0]           LBUS_EOP,
  input  logic [3:0]           LBUS_ERR,
  input  logic [15:0]          LBUS_MTY,
  output logic [511:0]         TX_MFB_DATA,
  output logic                 TX_MFB_SOF,
  output logic                 TX_MFB_EOF,
  output logic [2:0]           TX_MFB_SOF_POS,
  output logic [5:0]           TX_MFB_EOF_POS,
  output logic                 TX_MFB_META,
  output logic                 TX_MFB_SRC_RDY,
  input  logic                 TX_MFB_DST_RDY,
  output logic [CNT_WIDTH-1:0] DROP_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 512 + 1 + 1 + 3 + 6 + 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);
  localparam logic [AW:0] TWO_V   = (AW+1)'(2);

  typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

  // Stage 1: registered LBUS word
  logic [511:0] data_q;
  logic [3:0]   ena_q, sop_q, eop_q, err_q;
  logic [15:0]  mty_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q <= '0;
      ena_q  <= '0;
      sop_q  <= '0;
      eop_q  <= '0;
      err_q  <= '0;
      mty_q  <= '0;
    end else begin
      data_q <= LBUS_DATA;
      ena_q  <= LBUS_ENA;
      sop_q  <= LBUS_SOP;
      eop_q  <= LBUS_EOP;
      err_q  <= LBUS_ERR;
      mty_q  <= LBUS_MTY;
    end
  end

  // Word decode
  logic       vld, has_sop, has_eop, eop_after_sop, err_sel;
  logic [3:0] sop_v, eop_v, mty_sel;
  logic [1:0] sop_seg, eop_seg;
  logic [5:0] eop_pos;

  always_comb begin
    sop_v   = sop_q & ena_q;
    eop_v   = eop_q & ena_q;
    sop_seg = '0;
    eop_seg = '0;
    for (int s = 3; s >= 0; s--) begin
      if (sop_v[s]) sop_seg = 2'(s);
      if (eop_v[s]) eop_seg = 2'(s);
    end
  end

  assign vld           = |ena_q;
  assign has_sop       = |sop_v;
  assign has_eop       = |eop_v;
  assign mty_sel       = mty_q[4*eop_seg +: 4];
  assign err_sel       = err_q[eop_seg];
  assign eop_pos       = {eop_seg, 4'hF} - {2'b00, mty_sel};
  // Same-word EOP belongs to the new frame only when it sits at or after the SOP
  assign eop_after_sop = has_eop && (eop_seg >= sop_seg);

  // LBUS segment s byte b -> MFB item 16*s+b
  logic [511:0] mfb_data;
  always_comb begin
    mfb_data = '0;
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 16; b++) begin
        mfb_data[8*(16*s+b) +: 8] = data_q[128*s + 120 - 8*b +: 8];
      end
    end
  end

  // FIFO bookkeeping
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, free;
  logic          rd_en;

  assign free  = DEPTH_V - count_q;
  assign rd_en = (count_q != '0) && TX_MFB_DST_RDY;

  // Admission FSM
  state_t               state_q, state_d;
  logic                 wr_en, w_sof, w_eof, w_meta, drop_inc;
  logic [2:0]           w_sof_pos;
  logic [5:0]           w_eof_pos;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    w_sof     = 1'b0;
    w_eof     = 1'b0;
    w_sof_pos = '0;
    w_eof_pos = '0;
    w_meta    = 1'b0;
    drop_inc  = 1'b0;
    if (vld) begin
      if (state_q == FRAME) begin
        if (free >= TWO_V) begin
          wr_en = 1'b1;
          if (has_eop) begin
            w_eof     = 1'b1;
            w_eof_pos = eop_pos;
            w_meta    = err_sel;
            if (has_sop) begin
              w_sof     = 1'b1;
              w_sof_pos = {sop_seg, 1'b0};
            end else begin
              state_d = IDLE;
            end
          end
        end else if (free == ONE_V) begin
          // Last slot is reserved so a truncated frame can always be closed
          wr_en = 1'b1;
          w_eof = 1'b1;
          if (has_eop) begin
            w_eof_pos = eop_pos;
            w_meta    = err_sel;
            if (has_sop) begin
              drop_inc = 1'b1;
              state_d  = DISCARD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            w_eof_pos = 6'd63;
            w_meta    = 1'b1;
            drop_inc  = 1'b1;
            state_d   = DISCARD;
          end
        end
      end else if (has_sop) begin
        // IDLE, or DISCARD resyncing on a new frame (any EOP before the SOP is discarded)
        if (free >= TWO_V) begin
          wr_en     = 1'b1;
          w_sof     = 1'b1;
          w_sof_pos = {sop_seg, 1'b0};
          if (eop_after_sop) begin
            w_eof     = 1'b1;
            w_eof_pos = eop_pos;
            w_meta    = err_sel;
            state_d   = IDLE;
          end else begin
            state_d = FRAME;
          end
        end else begin
          drop_inc = 1'b1;
          state_d  = eop_after_sop ? IDLE : DISCARD;
        end
      end else if ((state_q == DISCARD) && has_eop) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(drop_inc);
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + ONE_V;
        2'b01:   count_q <= count_q - ONE_V;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; fall-through needs an asynchronous read port
  logic [EW-1:0] wr_entry, rd_entry;
  assign wr_entry = {mfb_data, w_sof, w_eof, w_sof_pos, w_eof_pos, w_meta};

  if (DEVICE == "ULTRASCALE") begin : g_lutram
    (* ram_style = "distributed" *) logic [EW-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end
    assign rd_entry = mem[rd_ptr_q];
  end else begin : g_generic
    logic [EW-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end
    assign rd_entry = mem[rd_ptr_q];
  end

  // Fields are forced to zero while empty so reset and idle outputs are clean
  assign TX_MFB_SRC_RDY = (count_q != '0);
  assign {TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS, TX_MFB_META} =
         TX_MFB_SRC_RDY ? rd_entry : '0;
  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_lbus_rx_to_mfb.sv
// tb/tb_lbus_rx_to_mfb.sv - directed self-checking bench for lbus_rx_to_mfb
module tb_lbus_rx_to_mfb;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [511:0] LBUS_DATA;
  logic [3:0]   LBUS_ENA, LBUS_SOP, LBUS_EOP, LBUS_ERR;
  logic [15:0]  LBUS_MTY;
  logic [511:0] TX_MFB_DATA;
  logic         TX_MFB_SOF, TX_MFB_EOF, TX_MFB_META, TX_MFB_SRC_RDY, TX_MFB_DST_RDY;
  logic [2:0]   TX_MFB_SOF_POS;
  logic [5:0]   TX_MFB_EOF_POS;
  logic [31:0]  DROP_CNT;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  lbus_rx_to_mfb #(.FIFO_DEPTH(16), .CNT_WIDTH(32), .DEVICE("ULTRASCALE")) dut (
    .CLK(CLK), .RESET(RESET),
    .LBUS_DATA(LBUS_DATA), .LBUS_ENA(LBUS_ENA), .LBUS_SOP(LBUS_SOP),
    .LBUS_EOP(LBUS_EOP), .LBUS_ERR(LBUS_ERR), .LBUS_MTY(LBUS_MTY),
    .TX_MFB_DATA(TX_MFB_DATA), .TX_MFB_SOF(TX_MFB_SOF), .TX_MFB_EOF(TX_MFB_EOF),
    .TX_MFB_SOF_POS(TX_MFB_SOF_POS), .TX_MFB_EOF_POS(TX_MFB_EOF_POS),
    .TX_MFB_META(TX_MFB_META), .TX_MFB_SRC_RDY(TX_MFB_SRC_RDY),
    .TX_MFB_DST_RDY(TX_MFB_DST_RDY), .DROP_CNT(DROP_CNT)
  );

  typedef struct {
    logic [511:0] data;
    logic         sof;
    logic         eof;
    logic [2:0]   sp;
    logic [5:0]   ep;
    logic         meta;
  } beat_t;

  beat_t cap_q[$];
  beat_t mon_b;

  // Accepted MFB words, sampled on the inactive edge
  always @(negedge CLK) begin
    if (!RESET && TX_MFB_SRC_RDY && TX_MFB_DST_RDY) begin
      mon_b.data = TX_MFB_DATA;
      mon_b.sof  = TX_MFB_SOF;
      mon_b.eof  = TX_MFB_EOF;
      mon_b.sp   = TX_MFB_SOF_POS;
      mon_b.ep   = TX_MFB_EOF_POS;
      mon_b.meta = TX_MFB_META;
      cap_q.push_back(mon_b);
    end
  end

  // LBUS word: segment s byte b carries (16*s+b)+seed
  function automatic logic [511:0] lbus_pat(input logic [7:0] seed);
    logic [511:0] d;
    d = '0;
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 16; b++)
        d[128*s + 127 - 8*b -: 8] = 8'(16*s + b) + seed;
    return d;
  endfunction

  // Expected MFB word: item i carries i+seed
  function automatic logic [511:0] mfb_pat(input logic [7:0] seed);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i) + seed;
    return d;
  endfunction

  task automatic drive(input logic [511:0] d, input logic [3:0] ena, input logic [3:0] sop,
                       input logic [3:0] eop, input logic [3:0] err, input logic [15:0] mty);
    @(posedge CLK); #2;
    LBUS_DATA = d; LBUS_ENA = ena; LBUS_SOP = sop; LBUS_EOP = eop; LBUS_ERR = err; LBUS_MTY = mty;
  endtask

  task automatic idle();
    drive('0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    tests++; if (TX_MFB_SRC_RDY !== 1'b0) begin fails++; $display("FAIL reset_src_rdy got %0b exp 0", TX_MFB_SRC_RDY); end
    tests++; if ({TX_MFB_SOF, TX_MFB_EOF, TX_MFB_META} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {TX_MFB_SOF, TX_MFB_EOF, TX_MFB_META}); end
    tests++; if ({TX_MFB_SOF_POS, TX_MFB_EOF_POS} !== 9'd0) begin fails++; $display("FAIL reset_pos got %0d/%0d exp 0/0", TX_MFB_SOF_POS, TX_MFB_EOF_POS); end
    tests++; if (TX_MFB_DATA !== 512'd0) begin fails++; $display("FAIL reset_data got %h exp 0", TX_MFB_DATA); end
    tests++; if (DROP_CNT !== 32'd0) begin fails++; $display("FAIL reset_drop_cnt got %0d exp 0", DROP_CNT); end
    wait_cyc(1);
    RESET = 1'b0;
    wait_cyc(1);
  endtask

  task automatic test_64b_frame();
    beat_t b;
    TX_MFB_DST_RDY = 1'b1;
    cap_q.delete();
    drive(lbus_pat(8'h10), 4'hF, 4'b0001, 4'b1000, 4'h0, 16'h0);
    @(negedge CLK);
    idle();
    @(negedge CLK);
    tests++; if (TX_MFB_SRC_RDY !== 1'b0) begin fails++; $display("FAIL 64b_latency1 got %0b exp 0", TX_MFB_SRC_RDY); end
    @(negedge CLK);
    tests++; if (TX_MFB_SRC_RDY !== 1'b1) begin fails++; $display("FAIL 64b_latency2 got %0b exp 1", TX_MFB_SRC_RDY); end
    wait_cyc(4);
    tests++; if (cap_q.size() != 1) begin fails++; $display("FAIL 64b_count got %0d exp 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      b = cap_q[0];
      tests++; if ({b.sof, b.eof, b.meta} !== 3'b110) begin fails++; $display("FAIL 64b_flags got %b exp 110", {b.sof, b.eof, b.meta}); end
      tests++; if (b.sp !== 3'd0 || b.ep !== 6'd63) begin fails++; $display("FAIL 64b_pos got %0d/%0d exp 0/63", b.sp, b.ep); end
      tests++; if (b.data !== mfb_pat(8'h10)) begin fails++; $display("FAIL 64b_data got %h exp %h", b.data, mfb_pat(8'h10)); end
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    cap_q.delete();
    drive(lbus_pat(8'h20), 4'hF, 4'b0001, 4'b0000, 4'h0, 16'h0);
    drive(lbus_pat(8'h21), 4'hF, 4'b0100, 4'b0010, 4'h0, 16'h0040);
    drive(lbus_pat(8'h22), 4'hF, 4'b0000, 4'b1000, 4'h0, 16'h0);
    idle();
    wait_cyc(6);
    tests++; if (cap_q.size() != 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", cap_q.size()); end
    if (cap_q.size() == 3) begin
      b = cap_q[0];
      tests++; if ({b.sof, b.eof} !== 2'b10 || b.sp !== 3'd0) begin fails++; $display("FAIL b2b_w0 got sof%0b eof%0b sp%0d exp 1 0 0", b.sof, b.eof, b.sp); end
      b = cap_q[1];
      tests++; if ({b.sof, b.eof} !== 2'b11) begin fails++; $display("FAIL b2b_w1_flags got %b exp 11", {b.sof, b.eof}); end
      tests++; if (b.ep !== 6'd27 || b.sp !== 3'd4) begin fails++; $display("FAIL b2b_w1_pos got eof%0d sof%0d exp 27 4", b.ep, b.sp); end
      tests++; if (b.data !== mfb_pat(8'h21)) begin fails++; $display("FAIL b2b_w1_data got %h exp %h", b.data, mfb_pat(8'h21)); end
      b = cap_q[2];
      tests++; if ({b.sof, b.eof, b.meta} !== 3'b010 || b.ep !== 6'd63) begin fails++; $display("FAIL b2b_w2 got %b ep%0d exp 010 63", {b.sof, b.eof, b.meta}, b.ep); end
    end
    tests++; if (DROP_CNT !== 32'd0) begin fails++; $display("FAIL b2b_drop got %0d exp 0", DROP_CNT); end
  endtask

  task automatic test_err_frame();
    beat_t b;
    cap_q.delete();
    drive(lbus_pat(8'h30), 4'hF, 4'b0001, 4'b0000, 4'h0, 16'h0);
    drive(lbus_pat(8'h31), 4'b0111, 4'b0000, 4'b0100, 4'b0100, 16'h0F00);
    idle();
    wait_cyc(6);
    tests++; if (cap_q.size() != 2) begin fails++; $display("FAIL err_count got %0d exp 2", cap_q.size()); end
    if (cap_q.size() == 2) begin
      b = cap_q[1];
      tests++; if ({b.eof, b.meta} !== 2'b11 || b.ep !== 6'd32) begin fails++; $display("FAIL err_eop got eof%0b meta%0b ep%0d exp 1 1 32", b.eof, b.meta, b.ep); end
    end
    tests++; if (DROP_CNT !== 32'd0) begin fails++; $display("FAIL err_drop got %0d exp 0", DROP_CNT); end
  endtask

  task automatic test_overflow();
    beat_t b;
    TX_MFB_DST_RDY = 1'b0;
    cap_q.delete();
    // 2000 B = 31 full words + one 16 B word
    for (int w = 0; w < 32; w++)
      drive(lbus_pat(8'(w) + 8'h40), (w == 31) ? 4'b0001 : 4'hF, (w == 0) ? 4'b0001 : 4'b0000,
            (w == 31) ? 4'b0001 : 4'b0000, 4'h0, 16'h0);
    idle();
    wait_cyc(4);
    tests++; if (TX_MFB_SRC_RDY !== 1'b1 || TX_MFB_SOF !== 1'b1) begin fails++; $display("FAIL ovf_hold_flags got rdy%0b sof%0b exp 1 1", TX_MFB_SRC_RDY, TX_MFB_SOF); end
    tests++; if (TX_MFB_DATA !== mfb_pat(8'h40)) begin fails++; $display("FAIL ovf_hold_data got %h exp %h", TX_MFB_DATA, mfb_pat(8'h40)); end
    tests++; if (DROP_CNT !== 32'd1) begin fails++; $display("FAIL ovf_drop got %0d exp 1", DROP_CNT); end
    TX_MFB_DST_RDY = 1'b1;
    wait_cyc(24);
    tests++; if (cap_q.size() != 16) begin fails++; $display("FAIL ovf_count got %0d exp 16", cap_q.size()); end
    if (cap_q.size() == 16) begin
      tests++; if (cap_q[0].sof !== 1'b1 || cap_q[14].eof !== 1'b0) begin fails++; $display("FAIL ovf_sof_eof got sof%0b eof14 %0b exp 1 0", cap_q[0].sof, cap_q[14].eof); end
      b = cap_q[15];
      tests++; if ({b.eof, b.meta} !== 2'b11 || b.ep !== 6'd63) begin fails++; $display("FAIL ovf_trunc got eof%0b meta%0b ep%0d exp 1 1 63", b.eof, b.meta, b.ep); end
      tests++; if (b.data !== mfb_pat(8'h4F)) begin fails++; $display("FAIL ovf_w15_data got %h exp %h", b.data, mfb_pat(8'h4F)); end
    end
    cap_q.delete();
    drive(lbus_pat(8'h60), 4'hF, 4'b0001, 4'b1000, 4'h0, 16'h0);
    idle();
    wait_cyc(5);
    tests++; if (cap_q.size() != 1) begin fails++; $display("FAIL ovf_next_count got %0d exp 1", cap_q.size()); end
    if (cap_q.size() == 1) begin
      b = cap_q[0];
      tests++; if ({b.sof, b.eof, b.meta} !== 3'b110 || b.ep !== 6'd63 || b.data !== mfb_pat(8'h60)) begin fails++; $display("FAIL ovf_next_frame got %b ep%0d exp 110 63", {b.sof, b.eof, b.meta}, b.ep); end
    end
    tests++; if (DROP_CNT !== 32'd1) begin fails++; $display("FAIL ovf_next_drop got %0d exp 1", DROP_CNT); end
  endtask

  task automatic test_drop_at_sop();
    int bad;
    TX_MFB_DST_RDY = 1'b0;
    cap_q.delete();
    for (int f = 0; f < 16; f++)
      drive(lbus_pat(8'(f) + 8'h80), 4'hF, 4'b0001, 4'b1000, 4'h0, 16'h0);
    idle();
    wait_cyc(4);
    tests++; if (DROP_CNT !== 32'd2) begin fails++; $display("FAIL sopdrop_cnt got %0d exp 2", DROP_CNT); end
    TX_MFB_DST_RDY = 1'b1;
    wait_cyc(22);
    tests++; if (cap_q.size() != 15) begin fails++; $display("FAIL sopdrop_count got %0d exp 15", cap_q.size()); end
    bad = 0;
    foreach (cap_q[i]) if (cap_q[i].sof !== 1'b1 || cap_q[i].eof !== 1'b1) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL sopdrop_flags got %0d bad words exp 0", bad); end
    if (cap_q.size() == 15) begin
      tests++; if (cap_q[14].data !== mfb_pat(8'h8E)) begin fails++; $display("FAIL sopdrop_last_data got %h exp %h", cap_q[14].data, mfb_pat(8'h8E)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    beat_t b;
    TX_MFB_DST_RDY = 1'b0;
    cap_q.delete();
    drive(lbus_pat(8'hA0), 4'hF, 4'b0001, 4'b0000, 4'h0, 16'h0);
    @(posedge CLK); #2;
    RESET = 1'b1;
    LBUS_ENA = 4'h0; LBUS_SOP = 4'h0; LBUS_EOP = 4'h0;
    wait_cyc(2);
    RESET = 1'b0;
    wait_cyc(1);
    tests++; if (DROP_CNT !== 32'd0 || TX_MFB_SRC_RDY !== 1'b0) begin fails++; $display("FAIL rst_mid_state got drop%0d rdy%0b exp 0 0", DROP_CNT, TX_MFB_SRC_RDY); end
    TX_MFB_DST_RDY = 1'b1;
    drive(lbus_pat(8'hA1), 4'hF, 4'b0000, 4'b1000, 4'h0, 16'h0);
    idle();
    wait_cyc(5);
    tests++; if (cap_q.size() != 0) begin fails++; $display("FAIL rst_mid_tail got %0d words exp 0", cap_q.size()); end
    tests++; if (DROP_CNT !== 32'd0) begin fails++; $display("FAIL rst_mid_drop got %0d exp 0", DROP_CNT); end
    drive(lbus_pat(8'hB0), 4'hF, 4'b0001, 4'b1000, 4'h0, 16'h0);
    idle();
    wait_cyc(5);
    tests++; if (cap_q.size() != 1) begin fails++; $display("FAIL rst_mid_next_count got %0d exp 1", cap_q.size()); end
    if (cap_q.size() == 1) begin
      b = cap_q[0];
      tests++; if ({b.sof, b.eof, b.meta} !== 3'b110 || b.ep !== 6'd63 || b.data !== mfb_pat(8'hB0)) begin fails++; $display("FAIL rst_mid_next_frame got %b ep%0d exp 110 63", {b.sof, b.eof, b.meta}, b.ep); end
    end
  endtask

  initial begin
    RESET = 1'b1;
    TX_MFB_DST_RDY = 1'b0;
    LBUS_DATA = '0; LBUS_ENA = '0; LBUS_SOP = '0; LBUS_EOP = '0; LBUS_ERR = '0; LBUS_MTY = '0;
    wait_cyc(3);
    test_reset();
    test_64b_frame();
    test_back_to_back();
    test_err_frame();
    test_overflow();
    test_drop_at_sop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
